fpu_issue_queue: RTL

Upstream issue stage for the combinational fpu. It buffers incoming FP commands (op1, op2, opsel, tag) in a small FIFO and presents one command at a time from an issue register to the fpu inputs. It captures the fpu result in a result register and hands results downstream with valid/ready handshakes. Results leave in command order, so the fpu can be driven from a CPU pipeline or a DMA command stream that stalls.

---
 rtl/fpu_issue_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: command FIFO, issue register and result register placed
// around a combinational fpu. Results leave in command order, and every stage
// holds its contents while stalled by downstream backpressure.
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     i_w_clk,
  input  logic                     i_w_rst_n,
  input  logic                     i_w_cmd_valid,
  output logic                     o_w_cmd_ready,
  input  logic [31:0]              i_w_cmd_op1,
  input  logic [31:0]              i_w_cmd_op2,
  input  logic [2:0]               i_w_cmd_sel,
  input  logic [TAG_W-1:0]         i_w_cmd_tag,
  output logic [31:0]              o_w_fpu_op1,
  output logic [31:0]              o_w_fpu_op2,
  output logic [2:0]               o_w_fpu_sel,
  input  logic [31:0]              i_w_fpu_out,
  output logic                     o_w_res_valid,
  input  logic                     i_w_res_ready,
  output logic [31:0]              o_w_res_data,
  output logic [TAG_W-1:0]         o_w_res_tag,
  output logic [$clog2(DEPTH):0]   o_w_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             cmd_in;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             iss_valid_q, iss_valid_d;
  cmd_t             iss_q, iss_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  logic             push, pop, res_adv, iss_adv;

  // Handshake terms; ready depends only on registered occupancy
  always_comb begin
    cmd_in        = '{op1: i_w_cmd_op1, op2: i_w_cmd_op2,
                      sel: i_w_cmd_sel, tag: i_w_cmd_tag};
    o_w_cmd_ready = (count_q != FULL);
    push          = i_w_cmd_valid && o_w_cmd_ready;
    res_adv       = !res_valid_q || i_w_res_ready;
    iss_adv       = !iss_valid_q || res_adv;
    pop           = iss_adv && (count_q != '0);
  end

  // Next-state for pointers, occupancy, issue and result registers
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Head is read from stored entries only, so a same-cycle push never bypasses
    if (iss_adv) begin
      if (pop) begin
        iss_d       = mem_q[rd_ptr_q];
        iss_valid_d = 1'b1;
      end else begin
        iss_valid_d = 1'b0;
      end
    end

    if (res_adv) begin
      res_data_d  = i_w_fpu_out;
      res_tag_d   = iss_q.tag;
      res_valid_d = iss_valid_q;
    end
  end

  // FIFO storage needs no reset: pointers and count define what is valid
  always_ff @(posedge i_w_clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Control and datapath registers with asynchronous clear
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    o_w_fpu_op1   = iss_q.op1;
    o_w_fpu_op2   = iss_q.op2;
    o_w_fpu_sel   = iss_q.sel;
    o_w_res_valid = res_valid_q;
    o_w_res_data  = res_data_q;
    o_w_res_tag   = res_tag_q;
    o_w_count     = count_q;
  end

endmodule
